// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller:
// state values, opcode constants, datapath select codes and the opcode class.
package rv_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC  = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    typedef struct packed {
        logic r;
        logic opimm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: maps instr[6:0] to a one-hot instruction
// class shared by every decode step of the sequencer.
module mc_opcode_class
    import rv_mc_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [7:0] o_class
);

    op_class_t w_class;

    // one-hot class; anything outside the supported set is illegal
    always_comb begin
        w_class = '0;
        case (i_opcode)
            OP_R:      w_class.r       = 1'b1;
            OP_IMM:    w_class.opimm   = 1'b1;
            OP_LOAD:   w_class.load    = 1'b1;
            OP_STORE:  w_class.store   = 1'b1;
            OP_BRANCH: w_class.branch  = 1'b1;
            OP_JAL:    w_class.jal     = 1'b1;
            OP_JALR:   w_class.jalr    = 1'b1;
            default:   w_class.illegal = 1'b1;
        endcase
    end

    assign o_class = w_class;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives the
// shared datapath selects and strobes, and counts retired instructions.
module multicycle_ctrl_fsm
    import rv_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    logic [7:0]       w_class_bits;
    op_class_t        w_class;
    state_e           r_state;
    state_e           w_next_state;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    mc_opcode_class u_opcode_class (
        .i_opcode (opcode),
        .o_class  (w_class_bits)
    );

    assign w_class = op_class_t'(w_class_bits);

    // state register and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_instret <= r_instret;
            end
        end
    end

    // next-state and datapath control decode; reset forces IDLE, so every
    // strobe drops in the same instant rst_n falls
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        pc_src       = PCSRC_ALU;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = M2R_ALUOUT;
        illegal_op   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                iord      = 1'b0;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = PCSRC_ALU;
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                if (w_class.illegal) begin
                    illegal_op   = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (w_class.r) begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    alu_op       = ALUOP_FUNCT;
                    w_next_state = ST_WB;
                end else if (w_class.opimm) begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = ALUOP_FUNCT;
                    w_next_state = ST_WB;
                end else if (w_class.load || w_class.store) begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = ALUOP_ADD;
                    w_next_state = ST_MEM;
                end else if (w_class.branch) begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    alu_op       = ALUOP_BR;
                    branch       = 1'b1;
                    pc_src       = PCSRC_ALUOUT;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_class.jal) begin
                    pc_write     = 1'b1;
                    pc_src       = PCSRC_ALUOUT;
                    reg_write    = 1'b1;
                    mem_to_reg   = M2R_PC;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_class.jalr) begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = ALUOP_ADD;
                    pc_write     = 1'b1;
                    pc_src       = PCSRC_ALU;
                    reg_write    = 1'b1;
                    mem_to_reg   = M2R_PC;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = w_class.load;
                mem_write = w_class.store;
                if (mem_ready) begin
                    if (w_class.load) begin
                        w_next_state = ST_WB;
                    end else begin
                        w_retire     = w_class.store;
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_next_state = ST_MEM;
                end
            end

            ST_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = w_class.load ? M2R_MDR : M2R_ALUOUT;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign instret = r_instret;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control pattern, checked every cycle.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_IMM  = 7'b0010011;
    localparam logic [6:0] T_LD   = 7'b0000011;
    localparam logic [6:0] T_ST   = 7'b0100011;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111;
    localparam logic [6:0] T_BAD  = 7'b1111111;

    localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_ILL = 7;

    typedef struct packed {
        logic [2:0] st;
        logic       req, iord, rd, wr, irw, pcw, br;
        logic [1:0] pcs, a, b, aop;
        logic       rw;
        logic [1:0] m2r;
        logic       ill;
    } sig_t;

    typedef struct packed {
        sig_t        s;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;

    logic        mem_req, iord, mem_read, mem_write, ir_write, pc_write, branch;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic        reg_write, illegal_op;
    logic [31:0] instret;
    logic [2:0]  state;

    logic        d4_mem_req, d4_iord, d4_mem_read, d4_mem_write, d4_ir_write, d4_pc_write, d4_branch;
    logic [1:0]  d4_pc_src, d4_alu_src_a, d4_alu_src_b, d4_alu_op, d4_mem_to_reg;
    logic        d4_reg_write, d4_illegal_op;
    logic [3:0]  d4_instret;
    logic [2:0]  d4_state;

    multicycle_ctrl_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .instret(instret), .state(state)
    );

    multicycle_ctrl_fsm #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(d4_mem_req), .iord(d4_iord), .mem_read(d4_mem_read), .mem_write(d4_mem_write),
        .ir_write(d4_ir_write), .pc_write(d4_pc_write), .branch(d4_branch), .pc_src(d4_pc_src),
        .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
        .reg_write(d4_reg_write), .mem_to_reg(d4_mem_to_reg), .illegal_op(d4_illegal_op),
        .instret(d4_instret), .state(d4_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    exp_t        cmp_e;
    int          errors = 0;
    int          checks = 0;
    int          lat    = 0;
    logic [31:0] model_cnt = 32'd0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int kind(input logic [6:0] op);
        case (op)
            T_R:     return K_R;
            T_IMM:   return K_IMM;
            T_LD:    return K_LD;
            T_ST:    return K_ST;
            T_BR:    return K_BR;
            T_JAL:   return K_JAL;
            T_JALR:  return K_JALR;
            default: return K_ILL;
        endcase
    endfunction

    function automatic sig_t quiet(input logic [2:0] st);
        sig_t s;
        s    = '0;
        s.st = st;
        return s;
    endfunction

    // one clock of stimulus plus the control pattern that cycle must show
    task automatic cyc(input logic [6:0] op, input logic rdy, input sig_t s, input bit retire);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        e.s   = s;
        e.cnt = model_cnt;
        exp_q.push_back(e);
        if (retire) model_cnt = model_cnt + 32'd1;
        lat++;
    endtask

    // expand one instruction; abort leaves it waiting in MEM
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit abort);
        sig_t s;
        int   k;
        bit   ret;
        k   = kind(op);
        lat = 0;
        s = quiet(3'd1); s.req = 1'b1; s.rd = 1'b1; s.b = 2'd1;
        for (int i = 0; i < fw; i++) cyc(op, 1'b0, s, 1'b0);
        s.irw = 1'b1; s.pcw = 1'b1;
        cyc(op, 1'b1, s, 1'b0);
        s = quiet(3'd2); s.a = 2'd2; s.b = 2'd2;
        if (k == K_ILL) begin
            s.ill = 1'b1;
            cyc(op, 1'b1, s, 1'b0);
            return;
        end
        cyc(op, 1'b1, s, 1'b0);
        s = quiet(3'd3);
        case (k)
            K_R:        begin s.a = 2'd1; s.b = 2'd0; s.aop = 2'd2; end
            K_IMM:      begin s.a = 2'd1; s.b = 2'd2; s.aop = 2'd2; end
            K_LD, K_ST: begin s.a = 2'd1; s.b = 2'd2; end
            K_BR:       begin s.a = 2'd1; s.b = 2'd0; s.aop = 2'd1; s.br = 1'b1; s.pcs = 2'd1; end
            K_JAL:      begin s.pcw = 1'b1; s.pcs = 2'd1; s.rw = 1'b1; s.m2r = 2'd2; end
            K_JALR:     begin s.a = 2'd1; s.b = 2'd2; s.pcw = 1'b1; s.rw = 1'b1; s.m2r = 2'd2; end
            default:    ;
        endcase
        ret = (k == K_BR) || (k == K_JAL) || (k == K_JALR);
        cyc(op, 1'b1, s, ret);
        if (ret) return;
        if (k == K_LD || k == K_ST) begin
            s = quiet(3'd4); s.req = 1'b1; s.iord = 1'b1;
            s.rd = (k == K_LD); s.wr = (k == K_ST);
            for (int i = 0; i < mw; i++) cyc(op, 1'b0, s, 1'b0);
            if (abort) return;
            cyc(op, 1'b1, s, k == K_ST);
            if (k == K_ST) return;
        end
        s = quiet(3'd5); s.rw = 1'b1; s.m2r = (k == K_LD) ? 2'd1 : 2'd0;
        cyc(op, 1'b1, s, 1'b1);
    endtask

    // one stalled fetch cycle, then pin the counters to literal values
    task automatic hold_check(input logic [31:0] lit, input logic [3:0] lit4);
        sig_t s;
        s = quiet(3'd1); s.req = 1'b1; s.rd = 1'b1; s.b = 2'd1;
        cyc(T_R, 1'b0, s, 1'b0);
        chk("lit_instret", 64'(instret), 64'(lit));
        chk("lit_instret4", 64'(d4_instret), 64'(lit4));
        chk("lit_state", 64'(state), 64'd1);
    endtask

    // per-cycle compare of both instances against the model queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk("outputs", 64'({state, mem_req, iord, mem_read, mem_write, ir_write, pc_write,
                                branch, pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
                                mem_to_reg, illegal_op}), 64'(cmp_e.s));
            chk("outputs4", 64'({d4_state, d4_mem_req, d4_iord, d4_mem_read, d4_mem_write,
                                 d4_ir_write, d4_pc_write, d4_branch, d4_pc_src, d4_alu_src_a,
                                 d4_alu_src_b, d4_alu_op, d4_reg_write, d4_mem_to_reg,
                                 d4_illegal_op}), 64'(cmp_e.s));
            chk("instret", 64'(instret), 64'(cmp_e.cnt));
            chk("instret4", 64'(d4_instret), 64'(cmp_e.cnt[3:0]));
        end
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = T_R;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 64'(state), 64'd0);
            chk("rst_mem_req", 64'(mem_req), 64'd0);
            chk("rst_instret", 64'(instret), 64'd0);
        end
        #1 rst_n = 1'b1;

        run_instr(T_R, 0, 0, 1'b0);    chk("lat_r", 64'(lat), 64'd4);
        hold_check(32'd1, 4'd1);
        run_instr(T_LD, 0, 2, 1'b0);   chk("lat_load_wait2", 64'(lat), 64'd7);
        run_instr(T_ST, 0, 0, 1'b0);   chk("lat_store", 64'(lat), 64'd4);
        run_instr(T_BR, 0, 0, 1'b0);   chk("lat_branch", 64'(lat), 64'd3);
        run_instr(T_JAL, 0, 0, 1'b0);  chk("lat_jal", 64'(lat), 64'd3);
        hold_check(32'd5, 4'd5);
        run_instr(T_BAD, 0, 0, 1'b0);  chk("lat_illegal", 64'(lat), 64'd2);
        hold_check(32'd5, 4'd5);
        run_instr(T_IMM, 1, 0, 1'b0);  chk("lat_opimm_fwait1", 64'(lat), 64'd5);
        run_instr(T_JALR, 0, 0, 1'b0); chk("lat_jalr", 64'(lat), 64'd3);
        hold_check(32'd7, 4'd7);

        // reset lands while a store is waiting in MEM
        run_instr(T_ST, 0, 2, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'd0);
        chk("async_mem_write", 64'(mem_write), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_instret", 64'(instret), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_cnt = 32'd0;

        for (int n = 0; n < 16; n++) run_instr(T_R, 0, 0, 1'b0);
        hold_check(32'd16, 4'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32I core, where one ALU, one unified memory port and one register-file write port are shared across the cycles of each instruction. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath mux selects and write strobes for each step. It holds on a memory ready/request handshake and counts retired instructions. It sits beside the register file, ALU and memory interface, replacing the single-cycle opcode decoder.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from instruction register (valid DECODE onward)
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request, held until mem_ready
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  read strobe (with mem_req)
mem_write  out  1  write strobe (with mem_req)
ir_write  out  1  load IR and old-PC register
pc_write  out  1  unconditional PC update
branch  out  1  PC update gated by ALU zero
pc_src  out  2  00 = ALU result, 01 = ALUOut
alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC
alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = immediate
alu_op  out  2  00 = add, 01 = branch compare, 10 = funct decode
reg_write  out  1  register-file write enable
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link)
illegal_op  out  1  one-cycle pulse on an unsupported opcode
instret  out  CNT_W  retired-instruction count
state  out  3  current state, for debug and bench

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Outputs are a Moore/Mealy decode of state, opcode and mem_ready. Any unlisted strobe is 0 and unlisted selects are 00.
- Reset (rst_n low, asynchronous): state=IDLE, instret=0. All strobes 0 immediately, including mid-instruction; no partial write completes.
- IDLE: no strobes; next cycle goes to FETCH.
- FETCH: mem_req=1, mem_read=1, iord=0, a=00, b=01, alu_op=00.
  - mem_ready=0: stay in FETCH, outputs stable.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=00 (PC+4), then DECODE.
  - Zero-wait-state fetch takes exactly one cycle.
- DECODE: a=10, b=10, alu_op=00 (ALUOut <- oldPC+imm).
  - Opcode 0110011 / 0010011 / 0000011 / 0100011 / 1100011 / 1101111 / 1100111 goes to EXEC.
  - Any other opcode: illegal_op=1 for this cycle, go to FETCH, instret unchanged.
- EXEC by opcode:
  - R (0110011): a=01, b=00, alu_op=10, then WB.
  - OP-IMM (0010011): a=01, b=10, alu_op=10, then WB.
  - LOAD/STORE: a=01, b=10, alu_op=00, then MEM.
  - BRANCH: a=01, b=00, alu_op=01, branch=1, pc_src=01, then FETCH (retire).
  - JAL: pc_write=1, pc_src=01, reg_write=1, mem_to_reg=10, then FETCH (retire).
  - JALR: a=01, b=10, alu_op=00, pc_write=1, pc_src=00, reg_write=1, mem_to_reg=10, then FETCH (retire).
  - Link for JAL/JALR is the current PC, already PC+4. rd==rs1 is safe because the read is combinational and the write lands at the edge.
- MEM: mem_req=1, iord=1, mem_read=LOAD, mem_write=STORE.
  - Hold while mem_ready=0.
  - On mem_ready: LOAD goes to WB; STORE goes to FETCH (retire).
- WB: reg_write=1; mem_to_reg=01 for LOAD, 00 otherwise; then FETCH (retire).
- mem_ready is ignored whenever mem_req=0.
- mem_req, iord and the strobes are stable for the whole wait.
- Store write-enable is asserted every wait cycle; memory commits once, on the mem_ready cycle.
- instret increments by 1 on every retire transition and wraps from 2^CNT_W-1 to 0.
- Opcode is sampled from IR only, so it is stable from DECODE to retire.
- Latency at zero wait states (cycles):
  - branch / JAL / JALR: 3
  - R / OP-IMM / store: 4
  - load: 5

Decomposition:
- Package rv_mc_pkg holds: state encodings, the seven opcode constants, and the select encodings for alu_src_a/b, alu_op, pc_src and mem_to_reg.
- One sub-module, mc_opcode_class: combinational opcode to one-hot class {r, opimm, load, store, branch, jal, jalr, illegal}. It is shared by the DECODE/EXEC/MEM/WB decode.

Test Plan:
- rst_n low 3 cycles, then high, mem_ready tied 1, R-type opcode: state 0,1,2,3,5,1. reg_write=1 only in WB. instret=1 after 5 cycles.
- LOAD with mem_ready low for 2 cycles in MEM: MEM held 3 cycles with mem_req=1, iord=1, mem_read=1 stable; then WB with mem_to_reg=01; total 7 cycles.
- STORE, BRANCH, JAL back-to-back, zero wait: 4+3+3 cycles; mem_write only in the store's MEM; branch=1 only in the branch EXEC; JAL EXEC shows pc_write=1, reg_write=1, mem_to_reg=10.
- Opcode 7'b1111111: illegal_op pulses exactly 1 cycle in DECODE; next state FETCH; instret unchanged.
- CNT_W=4, 16 R-type retires: instret returns to 0.
- rst_n dropped mid-MEM with mem_write=1: mem_req and mem_write fall in the same cycle (asynchronous); state=0; resumes at FETCH one cycle after release.
